// File: rtl/run_ctrl_if.sv
// Control/observation bundle between the run controller and the board/bench side.
// The slave side is run_ctrl itself; the master side drives start and watches status.
interface run_ctrl_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             i_start;
  logic             i_inst_vld;
  logic [PC_W-1:0]  i_pc;
  logic             o_core_rst_n;
  logic             o_running;
  logic             o_done;
  logic             o_halted;
  logic             o_timeout;
  logic [CNT_W-1:0] o_cycle_cnt;
  logic [CNT_W-1:0] o_inst_cnt;

  modport slave (
    input  i_start, i_inst_vld, i_pc,
    output o_core_rst_n, o_running, o_done, o_halted, o_timeout, o_cycle_cnt, o_inst_cnt
  );

  modport master (
    output i_start, i_inst_vld, i_pc,
    input  o_core_rst_n, o_running, o_done, o_halted, o_timeout, o_cycle_cnt, o_inst_cnt
  );
endinterface

// File: rtl/run_ctrl.sv
// Run controller for the RV32I core: reset sequencing, cycle/instruction counting,
// and run termination on a cycle budget or on a PC that keeps retiring in place.
module run_ctrl #(
  parameter int unsigned RST_CYCLES  = 5,
  parameter int unsigned MAX_CYCLES  = 500,
  parameter int unsigned HALT_CYCLES = 16,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned CNT_W       = 32
) (
  input  logic      i_clk,
  input  logic      i_rst,
  run_ctrl_if.slave bus
);

  localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned RPT_W = $clog2(HALT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [RST_W-1:0] rst_cnt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] inst_cnt;
  logic [RPT_W-1:0] rpt;
  logic [PC_W-1:0]  last_pc;
  logic             last_vld;
  logic             halted;
  logic             timeout;

  logic [CNT_W-1:0] cycle_inc;
  logic [RPT_W-1:0] rpt_nxt;
  logic             halt_hit;
  logic             time_hit;
  logic             start_load;

  // Next-value terms for the RUN-state bookkeeping
  always_comb begin
    cycle_inc = cycle_cnt + CNT_W'(1);
    rpt_nxt   = rpt;
    if (bus.i_inst_vld && last_vld && (bus.i_pc == last_pc)) begin
      rpt_nxt = rpt + RPT_W'(1);
    end else if (bus.i_inst_vld) begin
      rpt_nxt = '0;
    end
    halt_hit   = (rpt_nxt == RPT_W'(HALT_CYCLES));
    time_hit   = (cycle_inc == CNT_W'(MAX_CYCLES));
    start_load = ((state == S_IDLE) || (state == S_DONE)) && bus.i_start;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.i_start) state_nxt = S_RESET;
      S_RESET: if (rst_cnt == '0) state_nxt = S_RUN;
      S_RUN:   if (halt_hit || time_hit) state_nxt = S_DONE;
      S_DONE:  if (bus.i_start) state_nxt = S_RESET;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counters and sticky termination flags; frozen outside RESET/RUN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rst_cnt   <= '0;
      cycle_cnt <= '0;
      inst_cnt  <= '0;
      rpt       <= '0;
      last_pc   <= '0;
      last_vld  <= 1'b0;
      halted    <= 1'b0;
      timeout   <= 1'b0;
    end else if (start_load) begin
      rst_cnt   <= RST_W'(RST_CYCLES - 1);
      cycle_cnt <= '0;
      inst_cnt  <= '0;
      rpt       <= '0;
      last_vld  <= 1'b0;
      halted    <= 1'b0;
      timeout   <= 1'b0;
    end else if (state == S_RESET) begin
      if (rst_cnt != '0) begin
        rst_cnt <= rst_cnt - RST_W'(1);
      end
    end else if (state == S_RUN) begin
      cycle_cnt <= cycle_inc;
      rpt       <= rpt_nxt;
      if (bus.i_inst_vld) begin
        inst_cnt <= inst_cnt + CNT_W'(1);
        last_pc  <= bus.i_pc;
        last_vld <= 1'b1;
      end
      if (halt_hit) halted  <= 1'b1;
      if (time_hit) timeout <= 1'b1;
    end
  end

  // Status decoded straight from the state register so async reset shows at once
  assign bus.o_core_rst_n = (state == S_RUN);
  assign bus.o_running    = (state == S_RUN);
  assign bus.o_done       = (state == S_DONE);
  assign bus.o_halted     = halted;
  assign bus.o_timeout    = timeout;
  assign bus.o_cycle_cnt  = cycle_cnt;
  assign bus.o_inst_cnt   = inst_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed and randomized runs compared against
// a per-run reference model built from the run/halt/timeout rules.
module tb_run_ctrl;

  localparam int unsigned RST  = 5;
  localparam int unsigned MAX  = 500;
  localparam int unsigned HALT = 16;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  bit          stim_vld [MAX];
  logic [31:0] stim_pc  [MAX];

  run_ctrl_if #(.PC_W(32), .CNT_W(32)) bus ();

  run_ctrl #(
    .RST_CYCLES(RST), .MAX_CYCLES(MAX), .HALT_CYCLES(HALT), .PC_W(32), .CNT_W(32)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference: walk the stimulus cycle by cycle and stop at the first halt/budget edge
  task automatic model(output int e_end, output int e_inst, output bit e_h, output bit e_t);
    int          inst = 0;
    int          rep  = 0;
    bit          have = 0;
    logic [31:0] last = '0;
    e_end = 0; e_inst = 0; e_h = 0; e_t = 0;
    for (int k = 0; k < int'(MAX); k++) begin
      if (stim_vld[k]) begin
        inst++;
        if (have && stim_pc[k] == last) rep++;
        else rep = 0;
        last = stim_pc[k];
        have = 1;
      end
      if (rep == int'(HALT) || k + 1 == int'(MAX)) begin
        e_end = k + 1; e_inst = inst; e_h = (rep == int'(HALT)); e_t = (k + 1 == int'(MAX));
        break;
      end
    end
  endtask

  // Start a run from IDLE/DONE and play the stimulus arrays until o_done appears
  task automatic drive_run(output int rst_len, output int end_k);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    rst_len = 0;
    while (!bus.o_running && rst_len < 20) begin
      @(negedge clk);
      rst_len++;
    end
    end_k = -1;
    for (int k = 0; k < int'(MAX) + 4; k++) begin
      bus.i_inst_vld = (k < int'(MAX)) ? stim_vld[k] : 1'b0;
      bus.i_pc       = (k < int'(MAX)) ? stim_pc[k] : 32'h0;
      @(negedge clk);
      if (bus.o_done) begin
        end_k = k + 1;
        break;
      end
    end
    bus.i_inst_vld = 1'b0;
  endtask

  task automatic hit_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_inst_vld = 1'b0; bus.i_pc = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++; if (bus.o_core_rst_n !== 1'b0) begin tests_failed++; $display("FAIL reset_core_rst_n: got %b expected 0", bus.o_core_rst_n); end
    tests_run++; if (bus.o_running !== 1'b0) begin tests_failed++; $display("FAIL reset_running: got %b expected 0", bus.o_running); end
    tests_run++; if (bus.o_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.o_done); end
    tests_run++; if ({bus.o_halted, bus.o_timeout} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got %b expected 00", {bus.o_halted, bus.o_timeout}); end
    tests_run++; if (bus.o_cycle_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_cycle_cnt: got %0d expected 0", bus.o_cycle_cnt); end
    tests_run++; if (bus.o_inst_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_inst_cnt: got %0d expected 0", bus.o_inst_cnt); end
  endtask

  task automatic test_start_seq();
    logic exp;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    tests_run++; if (bus.o_core_rst_n !== 1'b0) begin tests_failed++; $display("FAIL start_edge0_rst_n: got %b expected 0", bus.o_core_rst_n); end
    for (int n = 1; n <= 6; n++) begin
      bus.i_start = (n == 2);
      @(negedge clk);
      exp = (n >= int'(RST));
      tests_run++;
      if (bus.o_core_rst_n !== exp || bus.o_running !== exp) begin
        tests_failed++;
        $display("FAIL start_edge%0d: got rst_n=%b running=%b expected %b", n, bus.o_core_rst_n, bus.o_running, exp);
      end
    end
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    tests_run++;
    if (bus.o_running !== 1'b1 || bus.o_cycle_cnt !== 32'd2) begin
      tests_failed++;
      $display("FAIL start_in_run: got running=%b cycle=%0d expected 1/2", bus.o_running, bus.o_cycle_cnt);
    end
    hit_reset();
  endtask

  task automatic check_run(input string name, input int rst_len, input int end_k);
    int e_end, e_inst;
    bit e_h, e_t;
    model(e_end, e_inst, e_h, e_t);
    tests_run++; if (rst_len !== int'(RST)) begin tests_failed++; $display("FAIL %s_rst_len: got %0d expected %0d", name, rst_len, RST); end
    tests_run++; if (end_k !== e_end) begin tests_failed++; $display("FAIL %s_end_cycle: got %0d expected %0d", name, end_k, e_end); end
    tests_run++; if (bus.o_cycle_cnt !== 32'(e_end)) begin tests_failed++; $display("FAIL %s_cycle_cnt: got %0d expected %0d", name, bus.o_cycle_cnt, e_end); end
    tests_run++; if (bus.o_inst_cnt !== 32'(e_inst)) begin tests_failed++; $display("FAIL %s_inst_cnt: got %0d expected %0d", name, bus.o_inst_cnt, e_inst); end
    tests_run++; if (bus.o_halted !== e_h) begin tests_failed++; $display("FAIL %s_halted: got %b expected %b", name, bus.o_halted, e_h); end
    tests_run++; if (bus.o_timeout !== e_t) begin tests_failed++; $display("FAIL %s_timeout: got %b expected %b", name, bus.o_timeout, e_t); end
    tests_run++;
    if (bus.o_core_rst_n !== 1'b0 || bus.o_running !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_frozen: got rst_n=%b running=%b expected 0/0", name, bus.o_core_rst_n, bus.o_running);
    end
  endtask

  task automatic test_timeout();
    int rl, ek;
    for (int k = 0; k < int'(MAX); k++) begin
      stim_vld[k] = (k % 2 == 1);
      stim_pc[k]  = 32'(4 * k);
    end
    drive_run(rl, ek);
    check_run("timeout", rl, ek);
    hit_reset();
  endtask

  task automatic test_halt();
    int rl, ek, k, nv;
    for (int i = 0; i < int'(MAX); i++) begin
      stim_vld[i] = 1'b0;
      stim_pc[i]  = $urandom;
    end
    k = 0; nv = 0;
    while (nv < 40) begin
      k += int'($urandom_range(0, 2));
      stim_vld[k] = 1'b1;
      stim_pc[k]  = (nv < 3) ? 32'(4 * nv) : 32'h8;
      nv++; k++;
    end
    drive_run(rl, ek);
    check_run("halt", rl, ek);
    hit_reset();
  endtask

  task automatic test_simultaneous();
    int rl, ek;
    for (int k = 0; k < int'(MAX); k++) begin
      stim_vld[k] = (k >= int'(MAX - HALT - 1));
      stim_pc[k]  = 32'h100;
    end
    drive_run(rl, ek);
    check_run("simul", rl, ek);
    // DONE must ignore retirements
    bus.i_inst_vld = 1'b1; bus.i_pc = 32'h100;
    repeat (3) @(negedge clk);
    bus.i_inst_vld = 1'b0;
    tests_run++;
    if (bus.o_inst_cnt !== 32'(HALT + 1) || bus.o_cycle_cnt !== 32'(MAX) || bus.o_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_frozen: got inst=%0d cycle=%0d done=%b expected %0d/%0d/1", bus.o_inst_cnt, bus.o_cycle_cnt, bus.o_done, HALT + 1, MAX);
    end
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    tests_run++;
    if ({bus.o_halted, bus.o_timeout, bus.o_done, bus.o_core_rst_n} !== 4'b0000 || bus.o_cycle_cnt !== 32'd0 || bus.o_inst_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL restart_clear: got h=%b t=%b d=%b rst_n=%b cycle=%0d inst=%0d expected all 0",
               bus.o_halted, bus.o_timeout, bus.o_done, bus.o_core_rst_n, bus.o_cycle_cnt, bus.o_inst_cnt);
    end
    rl = 0;
    while (!bus.o_running && rl < 20) begin
      @(negedge clk);
      rl++;
    end
    tests_run++; if (rl !== int'(RST)) begin tests_failed++; $display("FAIL restart_rst_len: got %0d expected %0d", rl, RST); end
    hit_reset();
  endtask

  task automatic test_random();
    int rl, ek;
    logic [31:0] cur;
    for (int r = 0; r < 4; r++) begin
      cur = 32'($urandom_range(0, 3)) << 2;
      for (int k = 0; k < int'(MAX); k++) begin
        stim_vld[k] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) cur = 32'($urandom_range(0, 3)) << 2;
        stim_pc[k] = stim_vld[k] ? cur : $urandom;
      end
      drive_run(rl, ek);
      check_run($sformatf("random%0d", r), rl, ek);
    end
    hit_reset();
  endtask

  task automatic test_async_reset();
    int rl;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    rl = 0;
    while (!bus.o_running && rl < 20) begin
      @(negedge clk);
      rl++;
    end
    for (int k = 0; k < 100; k++) begin
      bus.i_inst_vld = 1'b1;
      bus.i_pc       = 32'(4 * k);
      @(negedge clk);
    end
    bus.i_inst_vld = 1'b0;
    tests_run++;
    if (bus.o_cycle_cnt !== 32'd100 || bus.o_inst_cnt !== 32'd100 || bus.o_running !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_pre: got cycle=%0d inst=%0d running=%b expected 100/100/1", bus.o_cycle_cnt, bus.o_inst_cnt, bus.o_running);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.o_core_rst_n !== 1'b0 || bus.o_running !== 1'b0 || bus.o_cycle_cnt !== 32'd0 || bus.o_inst_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL async_immediate: got rst_n=%b running=%b cycle=%0d inst=%0d expected 0/0/0/0",
               bus.o_core_rst_n, bus.o_running, bus.o_cycle_cnt, bus.o_inst_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if ({bus.o_core_rst_n, bus.o_running, bus.o_done, bus.o_halted, bus.o_timeout} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL async_idle: got %b expected 00000", {bus.o_core_rst_n, bus.o_running, bus.o_done, bus.o_halted, bus.o_timeout});
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_start_seq();
    test_timeout();
    test_halt();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Synthesizable run controller for the RV32I core. It performs in hardware the reset sequencing and run-timeout supervision that the simulation bench does with tasks.
- It holds the core in reset for a programmable number of cycles after a start request, then counts cycles and retired instructions.
- It ends the run on a cycle budget (timeout) or on halt detection: the same PC retiring repeatedly, e.g. `jal x0,0`.
- It sits between the board/bench reset-and-control logic and `singlecycle`. It drives the core's active-low reset and observes the core's PC-debug and instruction-valid outputs.

Parameters:
- RST_CYCLES, 5: number of cycles core reset is held low in RESET; must be >= 1.
- MAX_CYCLES, 500: RUN-cycle budget before timeout; must be >= 1 and < 2^CNT_W.
- HALT_CYCLES, 16: consecutive repeated-PC retirements that declare a halt; must be >= 1.
- PC_W, 32: PC width.
- CNT_W, 32: width of the cycle and instruction counters.

Ports:
- i_clk, input, 1: clock.
- i_rst, input, 1: asynchronous active-high reset.
- i_start, input, 1: start/restart request, sampled on the rising edge.
- i_inst_vld, input, 1: core retired an instruction this cycle.
- i_pc, input, PC_W: PC of the retired instruction; valid when i_inst_vld=1.
- o_core_rst_n, output, 1: active-low reset to the core.
- o_running, output, 1: state == RUN.
- o_done, output, 1: state == DONE.
- o_halted, output, 1: run ended by halt detection (sticky until next start).
- o_timeout, output, 1: run ended by cycle budget (sticky until next start).
- o_cycle_cnt, output, CNT_W: RUN cycles elapsed in the current/last run.
- o_inst_cnt, output, CNT_W: instructions retired in RUN.

Behaviour:
- i_rst=1 (asynchronous, any state):
  - state goes to IDLE.
  - o_core_rst_n=0.
  - o_running, o_done, o_halted and o_timeout all 0.
  - Counters, repeat counter, last-PC register and last-PC-valid flag are cleared.
  - These values take effect immediately, without waiting for a clock edge.
- States: IDLE, RESET, RUN, DONE. All outputs are registered or decoded from state; no combinational path exists from inputs to outputs.
- o_core_rst_n=1 only in RUN. It is 0 in IDLE, RESET and DONE, so the core is frozen after the run.
- IDLE:
  - i_start=1 -> RESET.
  - Rst counter loads RST_CYCLES-1.
  - cycle/inst counters, flags, repeat counter and last-PC-valid are cleared.
- RESET:
  - Rst counter decrements each cycle; at 0 -> RUN.
  - o_core_rst_n is therefore low for exactly RST_CYCLES cycles after the start edge.
  - i_start is ignored.
- RUN, on each edge:
  - cycle_cnt <= cycle_cnt+1.
  - If i_inst_vld: inst_cnt <= inst_cnt+1.
  - If i_inst_vld and last-PC-valid and i_pc == last_pc: rpt <= rpt+1. Else if i_inst_vld: rpt <= 0.
  - If i_inst_vld: last_pc <= i_pc and last-PC-valid <= 1.
  - Cycles with i_inst_vld=0 leave rpt and last_pc unchanged.
  - Halt: next rpt == HALT_CYCLES -> o_halted <= 1 and state <= DONE at this edge. Halt therefore needs HALT_CYCLES+1 consecutive valid retirements at one PC.
  - Timeout: next cycle_cnt == MAX_CYCLES -> o_timeout <= 1 and state <= DONE at this edge.
  - Both conditions on the same edge: both flags are set.
  - i_start is ignored in RUN.
- DONE:
  - Counters, flags and last_pc are frozen.
  - i_inst_vld is ignored.
  - i_start=1 -> RESET with the same clearing as from IDLE.
- Counters never wrap. MAX_CYCLES < 2^CNT_W guarantees this, and inst_cnt <= cycle_cnt.
- Unused (`pc == 0`) is not special; PC 0 repeated halts like any other PC.

Test Plan:
- Power-up: i_rst=1 for 3 cycles then 0, no i_start -> state stays IDLE indefinitely; o_core_rst_n=0, all flags 0, counters 0.
- Start sequencing: i_start pulse at edge 0 with RST_CYCLES=5 -> o_core_rst_n low through edge 5, high and o_running=1 after edge 5. An i_start pulse during RESET/RUN has no effect.
- Timeout:
  - Stimulus: MAX_CYCLES=500, i_inst_vld=1 every other cycle, PC stepping by 4.
  - Required: after the 500th RUN edge, o_timeout=1, o_done=1, o_halted=0, o_cycle_cnt=500, o_inst_cnt=250, o_core_rst_n=0.
- Halt:
  - Stimulus: HALT_CYCLES=16; retire PCs 0x0, 0x4, 0x8, then 0x8 repeatedly, with 0-valid gaps interleaved.
  - Required: o_halted=1 and o_done=1 on the edge of the 17th valid retirement at 0x8. The gaps do not reset rpt. o_inst_cnt=19; o_timeout=0.
- Simultaneous: arrange the 16th repeat exactly on RUN cycle MAX_CYCLES -> o_halted=1 and o_timeout=1 together; then i_start in DONE -> flags and counters clear, new RESET of 5 cycles.
- Async reset mid-RUN: assert i_rst between clock edges at cycle 100 of RUN -> o_core_rst_n=0, o_running=0 and counters=0 immediately, before the next edge; after release, state is IDLE.
